pixel_dispatcher: RTL and testbench
===================================

// Module: pixel_dispatcher
// PURPOSE
// - Frame-level scheduler for the mandelbrot engine array: walks the screen raster and hands one pixel
//   coordinate at a time to idle engines.
// - Tracks per-engine busy state and round-robins grants among eligible engines.
// - Withholds grants from engines whose output queue is full; signals frame completion.
// - Sits between the frame-control logic and the NUM_ENGINES engines; replaces fixed per-engine coordinates.
// PARAMETERS
// - NUM_ENGINES  6    number of mandelbrot engines scheduled
// - DATA_WIDTH   32   width of coordinate outputs
// - SCREEN_W     640  pixels per line
// - SCREEN_H     480  lines per frame
// PORTS
// - clk          in   1             single clock, all logic on rising edge
// - reset        in   1             synchronous, active-low reset
// - frame_start  in   1             request to render one frame; sampled only in IDLE
// - full_queue   in   NUM_ENGINES   bit k=1: engine k's result queue is full, do not grant k
// - eng_done     in   NUM_ENGINES   bit k=1 (1-cycle pulse): engine k finished its pixel
// - eng_start    out  NUM_ENGINES   one-hot grant pulse; engine k latches eng_x/eng_y
// - eng_x        out  DATA_WIDTH    pixel x for the current grant (zero-extended)
// - eng_y        out  DATA_WIDTH    pixel y for the current grant (zero-extended)
// - busy         out  1             high from frame accept until frame_done
// - frame_done   out  1             1-cycle pulse when the last pixel of the frame has completed
// BEHAVIOUR
// - Reset (reset=0 at an edge): state=IDLE, eng_start=0, eng_x=eng_y=0, busy=0, frame_done=0,
//   busy_vec=0, rr_ptr=0, raster x=y=0.
// - Reset has priority over all other inputs, including mid-frame. Outstanding engine work is forgotten.
// - All outputs are registered.
// - FSM states: IDLE, DISPATCH, DRAIN, DONE.
// - IDLE -> DISPATCH when frame_start=1. Raster is set to (0,0); busy=1 from the next cycle.
// - frame_start is ignored in every other state.
// - Eligibility: engine k is eligible when busy_vec[k]=0 and full_queue[k]=0.
// - DISPATCH grant: each cycle at most one grant.
//   - Search eligible engines starting at rr_ptr, wrapping at NUM_ENGINES-1.
//   - On the first eligible k: next cycle eng_start[k]=1 with eng_x/eng_y = current raster.
//   - Same edge: busy_vec[k] set, rr_ptr = (k+1) mod NUM_ENGINES.
// - DISPATCH stall: no eligible engine gives eng_start=0, with raster and rr_ptr unchanged.
// - Raster advance: x increments per grant; at x=SCREEN_W-1, x wraps to 0 and y increments.
// - After granting (SCREEN_W-1, SCREEN_H-1): DISPATCH -> DRAIN. The raster holds and no further grants are made.
// - eng_done[k] clears busy_vec[k] at that edge, so engine k is eligible for a grant decided the same cycle.
// - eng_done for a non-busy engine is ignored.
// - A grant and a done for different engines in the same cycle are both honoured.
// - DRAIN -> DONE when busy_vec==0 (after done updates). DONE: frame_done=1 for 1 cycle, busy=0, then IDLE.
// - Latency: frame_start edge -> first eng_start = 2 cycles.
// - Latency: last eng_done -> frame_done = 2 cycles (DRAIN detect, DONE pulse).
// - Raster counters are $clog2(SCREEN_W) / $clog2(SCREEN_H) bits. Comparisons use SCREEN_W-1 and SCREEN_H-1 exactly.
// CONFIGURATION
// - Macro DISPATCH_STATS_EN.
// - When defined, adds two outputs:
//   - stall_cycles (32): count of DISPATCH cycles with no grant.
//   - grant_count (32): count of grants in the frame.
//   - Both clear on reset and on frame accept. Both hold after frame_done. Both saturate at 2^32-1.
// - When undefined: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING (SCREEN_W=4, SCREEN_H=2, NUM_ENGINES=3)
// - Base frame: frame_start; engines pulse done 3 cycles after start.
//   -> 8 grants in order (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
//   -> First grants go to engines 0,1,2 on consecutive cycles.
//   -> frame_done fires 2 cycles after the final done; busy falls with it.
// - full_queue[0]=1 all frame -> eng_start[0] never asserted; grants alternate engines 1,2.
// - Engine 1 withholds done after its first grant -> engine 1 is not re-granted and FSM sits in DRAIN.
//   Releasing done -> frame_done 2 cycles later.
// - Mid-frame: frame_start pulsed during DISPATCH -> ignored; exactly 8 grants, one frame_done.
// - reset=0 for one edge mid-DISPATCH -> all outputs 0, IDLE. A new frame_start restarts at (0,0) on engine 0.
// - DISPATCH_STATS_EN, all engines held busy 5 cycles -> stall_cycles counts 5-cycle stall windows; grant_count=8.

Source files
------------

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks the screen raster and hands one pixel coordinate
// per cycle to an idle mandelbrot engine, round-robin among eligible engines.
// Engines with a full result queue are skipped; frame_done pulses once every
// granted pixel has been reported back.
// Optional feature macro: DISPATCH_STATS_EN adds stall_cycles / grant_count.
module pixel_dispatcher #(
  parameter int NUM_ENGINES = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [NUM_ENGINES-1:0] full_queue,
  input  logic [NUM_ENGINES-1:0] eng_done,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [DATA_WIDTH-1:0]  eng_x,
  output logic [DATA_WIDTH-1:0]  eng_y,
  output logic                   busy,
  output logic                   frame_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            grant_count
`endif
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int X_W   = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int Y_W   = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [PTR_W-1:0] LAST_ENG = PTR_W'(NUM_ENGINES - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NUM_ENGINES-1:0] r_busy_vec;
  logic [NUM_ENGINES-1:0] w_busy_after_done;
  logic [NUM_ENGINES-1:0] w_eligible;
  logic [NUM_ENGINES-1:0] w_grant_onehot;
  logic                   w_grant_valid;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [PTR_W-1:0]       w_idx_p;
  int                     w_idx;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [X_W-1:0]         r_x;
  logic [Y_W-1:0]         r_y;
  logic                   w_last_pixel;
  logic [NUM_ENGINES-1:0] r_eng_start;
  logic [DATA_WIDTH-1:0]  r_eng_x;
  logic [DATA_WIDTH-1:0]  r_eng_y;
  logic                   r_busy;
  logic                   r_frame_done;

  // A done pulse frees its engine in time for the grant decided this cycle;
  // done for an engine that is not busy simply has nothing to clear.
  assign w_busy_after_done = r_busy_vec & ~eng_done;
  assign w_eligible        = ~w_busy_after_done & ~full_queue;
  assign w_last_pixel      = (r_x == X_LAST) && (r_y == Y_LAST);

  assign eng_start  = r_eng_start;
  assign eng_x      = r_eng_x;
  assign eng_y      = r_eng_y;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  // Round-robin search for the first eligible engine starting at r_rr_ptr.
  always_comb begin
    w_grant_valid  = 1'b0;
    w_grant_idx    = '0;
    w_grant_onehot = '0;
    w_idx          = 0;
    w_idx_p        = '0;
    if (r_state == DISPATCH) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        w_idx = int'(r_rr_ptr) + i;
        if (w_idx >= NUM_ENGINES) w_idx = w_idx - NUM_ENGINES;
        w_idx_p = PTR_W'(w_idx);
        if (!w_grant_valid && w_eligible[w_idx_p]) begin
          w_grant_valid           = 1'b1;
          w_grant_idx             = w_idx_p;
          w_grant_onehot[w_idx_p] = 1'b1;
        end
      end
    end
  end

  // Frame sequencing: accept, dispatch every pixel, wait for engines, pulse done.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (frame_start) w_state_next = DISPATCH;
      DISPATCH: if (w_grant_valid && w_last_pixel) w_state_next = DRAIN;
      DRAIN:    if (w_busy_after_done == '0) w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Grant outputs, engine bookkeeping and raster walk; reset drops any outstanding work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_eng_start  <= '0;
      r_eng_x      <= '0;
      r_eng_y      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy_vec   <= '0;
      r_rr_ptr     <= '0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_eng_start  <= w_grant_onehot;
      r_frame_done <= (r_state == DONE);
      r_busy_vec   <= w_busy_after_done | w_grant_onehot;
      if (r_state == IDLE && frame_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_busy <= 1'b1;
      end
      if (r_state == DONE) r_busy <= 1'b0;
      if (w_grant_valid) begin
        r_eng_x  <= DATA_WIDTH'(r_x);
        r_eng_y  <= DATA_WIDTH'(r_y);
        r_rr_ptr <= (w_grant_idx == LAST_ENG) ? '0 : w_grant_idx + 1'b1;
        if (!w_last_pixel) begin
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_grant_count;

  assign stall_cycles = r_stall_cycles;
  assign grant_count  = r_grant_count;

  // Per-frame saturating counters of dispatch stalls and grants; they hold after the frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_grant_count  <= '0;
    end else if (r_state == IDLE && frame_start) begin
      r_stall_cycles <= '0;
      r_grant_count  <= '0;
    end else if (r_state == DISPATCH) begin
      if (w_grant_valid) begin
        if (r_grant_count != '1) r_grant_count <= r_grant_count + 1'b1;
      end else begin
        if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher: drives pixel_dispatcher with a small screen (4x2) and
// three engines, and compares every cycle against a behavioural scheduler
// model written from the frame/pixel/engine rules.
module tb_pixel_dispatcher;

  localparam int NE   = 3;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int SH   = 2;
  localparam int NPIX = SW * SH;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [NE-1:0] full_queue;
  logic [NE-1:0] eng_done;
  logic [NE-1:0] eng_start;
  logic [DW-1:0] eng_x;
  logic [DW-1:0] eng_y;
  logic          busy;
  logic          frame_done;
`ifdef DISPATCH_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   grant_count;
`endif

  always #5 clk = ~clk;

  pixel_dispatcher #(
    .NUM_ENGINES(NE),
    .DATA_WIDTH (DW),
    .SCREEN_W   (SW),
    .SCREEN_H   (SH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .full_queue (full_queue),
    .eng_done   (eng_done),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef DISPATCH_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .grant_count (grant_count)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  // round-robin pointer survives between frames, cleared only by reset
  int m_ptr = 0;

  // scenario knobs
  logic [NE-1:0] g_fq_fixed;
  int g_fq_rand, g_dmin, g_dmax, g_spurious, g_hold_eng, g_hold_until, g_mid_fs, g_max;

  // per-frame observations
  int    r_err, r_grants, r_fd_count, r_fd_cycle, r_last_done, r_release;
  int    r_timeout, r_repeat, r_stalls;
  int    r_per_eng[NE];
  int    r_first_eng[3];
  string r_first;

  task automatic set_defaults();
    g_fq_fixed   = '0;
    g_fq_rand    = 0;
    g_dmin       = 3;
    g_dmax       = 3;
    g_spurious   = 0;
    g_hold_eng   = -1;
    g_hold_until = 0;
    g_mid_fs     = -1;
    g_max        = 300;
  endtask

  // Runs one frame from IDLE: engine behaviour models react to grants, and the
  // scheduler model predicts each cycle's outputs. Starts and ends at a negedge.
  task automatic run_frame();
    bit            m_busy[NE];
    bit            m_active, m_fd_next, finished, fs, all_idle;
    int            m_n, exp_x, exp_y, last_eng, pick, k;
    logic [NE-1:0] exp_start, d, fq;
    bit            exp_busy, exp_fd;
    int            tb_cnt[NE];
    bit            tb_busy[NE];
    bit            tb_pend[NE];

    r_err = 0; r_grants = 0; r_fd_count = 0; r_fd_cycle = -1; r_last_done = -1;
    r_release = -1; r_timeout = 0; r_repeat = 0; r_stalls = 0; r_first = "";
    for (int i = 0; i < NE; i++) begin
      m_busy[i] = 0; tb_cnt[i] = 0; tb_busy[i] = 0; tb_pend[i] = 0; r_per_eng[i] = 0;
    end
    for (int i = 0; i < 3; i++) r_first_eng[i] = -1;
    m_active = 0; m_fd_next = 0; finished = 0; m_n = 0; exp_x = 0; exp_y = 0;
    exp_start = '0; exp_busy = 0; exp_fd = 0; last_eng = -1;

    for (int c = 0; c < g_max && !finished; c++) begin
      if (c > 0) begin
        if (eng_start !== exp_start || busy !== exp_busy || frame_done !== exp_fd ||
            (exp_start != '0 && (eng_x !== DW'(exp_x) || eng_y !== DW'(exp_y)))) begin
          r_err++;
          if (r_first == "")
            r_first = $sformatf("cycle %0d start=%b want %b xy=%0d,%0d want %0d,%0d busy=%b want %b done=%b want %b",
                                c, eng_start, exp_start, eng_x, eng_y, exp_x, exp_y,
                                busy, exp_busy, frame_done, exp_fd);
        end
        if (frame_done === 1'b1) begin
          r_fd_count++;
          if (r_fd_cycle < 0) r_fd_cycle = c;
        end
        if (exp_fd) finished = 1;
      end
      if (!finished) begin
        // engines count down their work, then latch any new grant
        for (int i = 0; i < NE; i++)
          if (tb_cnt[i] > 0) begin
            tb_cnt[i]--;
            if (tb_cnt[i] == 0) tb_pend[i] = 1;
          end
        for (int i = 0; i < NE; i++)
          if (eng_start[i] === 1'b1) begin
            r_grants++;
            r_per_eng[i]++;
            if (r_grants <= 3) r_first_eng[r_grants-1] = i;
            if (i == last_eng) r_repeat++;
            last_eng   = i;
            tb_busy[i] = 1;
            tb_cnt[i]  = $urandom_range(g_dmax, g_dmin);
          end
        d = '0;
        for (int i = 0; i < NE; i++)
          if (tb_pend[i] && !(i == g_hold_eng && c < g_hold_until)) begin
            d[i] = 1'b1; tb_pend[i] = 0; tb_busy[i] = 0; r_last_done = c;
            if (i == g_hold_eng) r_release = c;
          end
        if (g_spurious != 0)
          for (int i = 0; i < NE; i++)
            if (!tb_busy[i] && !d[i] && $urandom_range(7, 0) == 0) d[i] = 1'b1;
        fq = g_fq_fixed;
        if (g_fq_rand != 0) fq = fq | (NE'($urandom) & NE'($urandom));
        fs = (c == 0) || (c == g_mid_fs);
        frame_start = fs;
        full_queue  = fq;
        eng_done    = d;

        // predicted effect of the coming rising edge
        exp_start = '0;
        exp_fd    = 0;
        if (m_fd_next) begin
          exp_fd = 1; exp_busy = 0; m_active = 0; m_fd_next = 0;
        end else if (!m_active) begin
          if (fs) begin
            m_active = 1; m_n = 0; exp_busy = 1;
          end
        end else begin
          for (int i = 0; i < NE; i++) if (d[i]) m_busy[i] = 0;
          if (m_n < NPIX) begin
            pick = -1;
            for (int i = 0; i < NE; i++) begin
              k = (m_ptr + i) % NE;
              if (pick < 0 && !m_busy[k] && !fq[k]) pick = k;
            end
            if (pick >= 0) begin
              exp_start[pick] = 1'b1;
              exp_x = m_n % SW;
              exp_y = m_n / SW;
              m_busy[pick] = 1;
              m_ptr = (pick + 1) % NE;
              m_n++;
            end else begin
              r_stalls++;
            end
          end
          all_idle = 1;
          for (int i = 0; i < NE; i++) if (m_busy[i]) all_idle = 0;
          if (m_n == NPIX && all_idle) m_fd_next = 1;
        end
        @(negedge clk);
      end
    end
    if (!finished) r_timeout = 1;
    frame_start = 1'b0;
    eng_done    = '0;
    full_queue  = '0;
  endtask

  task automatic test_reset();
    frame_start = 1'b1;
    full_queue  = NE'($urandom);
    eng_done    = NE'($urandom);
    repeat (3) @(negedge clk);
    n_vec++; if (eng_start !== '0) begin n_miss++; $display("[TB] FAIL reset_start: got %b, expected 0", eng_start); end
    n_vec++; if (eng_x !== '0) begin n_miss++; $display("[TB] FAIL reset_x: got %0d, expected 0", eng_x); end
    n_vec++; if (eng_y !== '0) begin n_miss++; $display("[TB] FAIL reset_y: got %0d, expected 0", eng_y); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_done: got %b, expected 0", frame_done); end
`ifdef DISPATCH_STATS_EN
    n_vec++; if (stall_cycles !== 32'd0) begin n_miss++; $display("[TB] FAIL reset_stalls: got %0d, expected 0", stall_cycles); end
    n_vec++; if (grant_count !== 32'd0) begin n_miss++; $display("[TB] FAIL reset_grants: got %0d, expected 0", grant_count); end
`endif
    frame_start = 1'b0;
    full_queue  = '0;
    eng_done    = '0;
    reset       = 1'b1;
    m_ptr       = 0;
  endtask

  task automatic test_base_frame();
    set_defaults();
    run_frame();
    n_vec++; if (r_timeout !== 0) begin n_miss++; $display("[TB] FAIL base_timeout: got timeout, expected frame_done"); end
    n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL base_model: %0d bad cycles, expected 0; first %s", r_err, r_first); end
    n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL base_grants: got %0d, expected %0d", r_grants, NPIX); end
    n_vec++;
    if (r_first_eng[0] !== 0 || r_first_eng[1] !== 1 || r_first_eng[2] !== 2) begin
      n_miss++;
      $display("[TB] FAIL base_first_engines: got %0d,%0d,%0d, expected 0,1,2", r_first_eng[0], r_first_eng[1], r_first_eng[2]);
    end
    n_vec++; if (r_fd_count !== 1) begin n_miss++; $display("[TB] FAIL base_done_count: got %0d, expected 1", r_fd_count); end
    n_vec++; if (r_fd_cycle - r_last_done !== 2) begin n_miss++; $display("[TB] FAIL base_done_latency: got %0d, expected 2", r_fd_cycle - r_last_done); end
`ifdef DISPATCH_STATS_EN
    n_vec++; if (grant_count !== 32'(NPIX)) begin n_miss++; $display("[TB] FAIL base_grant_count: got %0d, expected %0d", grant_count, NPIX); end
    n_vec++; if (stall_cycles !== 32'(r_stalls)) begin n_miss++; $display("[TB] FAIL base_stall_count: got %0d, expected %0d", stall_cycles, r_stalls); end
`endif
  endtask

  task automatic test_full_queue();
    set_defaults();
    g_fq_fixed = 3'b001;
    run_frame();
    n_vec++; if (r_timeout !== 0) begin n_miss++; $display("[TB] FAIL fq_timeout: got timeout, expected frame_done"); end
    n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL fq_model: %0d bad cycles, expected 0; first %s", r_err, r_first); end
    n_vec++; if (r_per_eng[0] !== 0) begin n_miss++; $display("[TB] FAIL fq_engine0: got %0d grants, expected 0", r_per_eng[0]); end
    n_vec++; if (r_repeat !== 0) begin n_miss++; $display("[TB] FAIL fq_alternate: got %0d repeats, expected 0", r_repeat); end
    n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL fq_grants: got %0d, expected %0d", r_grants, NPIX); end
  endtask

  task automatic test_withheld_done();
    set_defaults();
    g_hold_eng   = 1;
    g_hold_until = 40;
    run_frame();
    n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL hold_model: %0d bad cycles, expected 0; first %s", r_err, r_first); end
    n_vec++; if (r_per_eng[1] !== 1) begin n_miss++; $display("[TB] FAIL hold_engine1: got %0d grants, expected 1", r_per_eng[1]); end
    n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL hold_grants: got %0d, expected %0d", r_grants, NPIX); end
    n_vec++; if (r_release !== 40) begin n_miss++; $display("[TB] FAIL hold_release: got cycle %0d, expected 40", r_release); end
    n_vec++; if (r_fd_cycle - r_release !== 2) begin n_miss++; $display("[TB] FAIL hold_done_latency: got %0d, expected 2", r_fd_cycle - r_release); end
  endtask

  task automatic test_mid_frame_start();
    set_defaults();
    g_mid_fs = 6;
    g_dmin   = 1;
    g_dmax   = 4;
    run_frame();
    n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL mid_model: %0d bad cycles, expected 0; first %s", r_err, r_first); end
    n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL mid_grants: got %0d, expected %0d", r_grants, NPIX); end
    n_vec++; if (r_fd_count !== 1) begin n_miss++; $display("[TB] FAIL mid_done_count: got %0d, expected 1", r_fd_count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || eng_start !== '0 || frame_done !== 1'b0) begin
        n_miss++;
        $display("[TB] FAIL mid_after_idle: got busy=%b start=%b done=%b, expected all 0", busy, eng_start, frame_done);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    n_vec++;
    if (eng_start !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_ctrl: got start=%b busy=%b done=%b, expected all 0", eng_start, busy, frame_done);
    end
    n_vec++;
    if (eng_x !== '0 || eng_y !== '0) begin
      n_miss++;
      $display("[TB] FAIL rst_mid_xy: got %0d,%0d, expected 0,0", eng_x, eng_y);
    end
    set_defaults();
    run_frame();
    n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL rst_mid_model: %0d bad cycles, expected 0; first %s", r_err, r_first); end
    n_vec++; if (r_first_eng[0] !== 0) begin n_miss++; $display("[TB] FAIL rst_mid_first_engine: got %0d, expected 0", r_first_eng[0]); end
    n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL rst_mid_grants: got %0d, expected %0d", r_grants, NPIX); end
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    set_defaults();
    g_dmin = 5;
    g_dmax = 5;
    run_frame();
    repeat (2) @(negedge clk);
    n_vec++; if (grant_count !== 32'(NPIX)) begin n_miss++; $display("[TB] FAIL stats_grants: got %0d, expected %0d", grant_count, NPIX); end
    n_vec++; if (stall_cycles !== 32'(r_stalls)) begin n_miss++; $display("[TB] FAIL stats_stalls: got %0d, expected %0d", stall_cycles, r_stalls); end
  endtask
`endif

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      set_defaults();
      g_dmin     = 1;
      g_dmax     = 5;
      g_fq_rand  = 1;
      g_spurious = 1;
      g_max      = 400;
      run_frame();
      n_vec++; if (r_timeout !== 0) begin n_miss++; $display("[TB] FAIL rand_timeout: frame %0d got timeout, expected frame_done", f); end
      n_vec++; if (r_err !== 0) begin n_miss++; $display("[TB] FAIL rand_model: frame %0d %0d bad cycles, expected 0; first %s", f, r_err, r_first); end
      n_vec++; if (r_grants !== NPIX) begin n_miss++; $display("[TB] FAIL rand_grants: frame %0d got %0d, expected %0d", f, r_grants, NPIX); end
      n_vec++; if (r_fd_count !== 1) begin n_miss++; $display("[TB] FAIL rand_done_count: frame %0d got %0d, expected 1", f, r_fd_count); end
      // idle gap with stray done pulses, which must be ignored
      repeat ($urandom_range(2, 0)) begin
        eng_done = NE'($urandom);
        @(negedge clk);
      end
      eng_done = '0;
    end
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    full_queue  = '0;
    eng_done    = '0;
    set_defaults();
    test_reset();
    test_base_frame();
    test_full_queue();
    test_withheld_done();
    test_mid_frame_start();
    test_reset_mid_frame();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
